frame_deserializer: RTL and testbench

- Receive-side counterpart of the word serializer: accepts a stream of BIT-wide words with valid/ready and a last-word marker, and rebuilds a parallel frame of up to NDATA words.
- Presents the frame on an unpacked array output with its own valid/ready handshake, plus word count and short/truncated status.
- Sits between a serial word link and parallel processing stages in the datapath.

---
 rtl/shiftreg_pkg.sv | 17 +
 rtl/frame_deserializer.sv | 131 +++++++++++++
 tb/tb_frame_deserializer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/shiftreg_pkg.sv
// Shared types and helpers for the frame deserializer.
//   deser_state_t : FSM states (COLLECT, HOLD, DROP)
//   count_width() : bits needed to hold a word count of 0..n
package shiftreg_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    HOLD    = 2'd1,
    DROP    = 2'd2
  } deser_state_t;

  // Width of a counter that must represent 0..n inclusive.
  function automatic int unsigned count_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/frame_deserializer.sv
// Rebuilds a parallel frame of up to NDATA words from a valid/ready word
// stream with a last-word marker, and presents it with its own handshake.
// Ports:
//   i_clk, i_rst       clock, asynchronous active-high reset
//   i_valid/o_ready    input word handshake; i_data word, i_last end-of-frame
//   o_valid/i_ready    frame handshake
//   o_data[0:NDATA-1]  frame slots, slot 0 = first word, unused slots = PAD
//   o_count            valid words in frame (1..NDATA)
//   o_short            frame ended by i_last before NDATA words
//   o_trunc            NDATA words seen without i_last; excess being dropped
module frame_deserializer
  import shiftreg_pkg::*;
#(
  parameter int unsigned    BIT   = 8,
  parameter int unsigned    NDATA = 3,
  parameter logic [BIT-1:0] PAD   = '0,
  localparam int unsigned   CW    = count_width(NDATA)
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_valid,
  output logic           o_ready,
  input  logic [BIT-1:0] i_data,
  input  logic           i_last,
  output logic           o_valid,
  input  logic           i_ready,
  output logic [BIT-1:0] o_data [0:NDATA-1],
  output logic [CW-1:0]  o_count,
  output logic           o_short,
  output logic           o_trunc
);

  deser_state_t   r_state, w_state_n;
  logic [CW-1:0]  r_idx, w_idx_n;
  logic [BIT-1:0] r_slot [0:NDATA-1];
  logic [BIT-1:0] w_slot_n [0:NDATA-1];
  logic [CW-1:0]  r_count, w_count_n;
  logic           r_short, w_short_n;
  logic           r_trunc, w_trunc_n;
  logic           r_valid, w_valid_n;
  logic           r_ready, w_ready_n;
  logic           w_accept;

  assign w_accept = i_valid && r_ready;

  // State and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= COLLECT;
      r_idx   <= '0;
      for (int i = 0; i < int'(NDATA); i++) r_slot[i] <= PAD;
      r_count <= '0;
      r_short <= 1'b0;
      r_trunc <= 1'b0;
      r_valid <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_idx   <= w_idx_n;
      r_slot  <= w_slot_n;
      r_count <= w_count_n;
      r_short <= w_short_n;
      r_trunc <= w_trunc_n;
      r_valid <= w_valid_n;
      r_ready <= w_ready_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_idx;
    w_slot_n  = r_slot;
    w_count_n = r_count;
    w_short_n = r_short;
    w_trunc_n = r_trunc;

    case (r_state)
      COLLECT: begin
        if (w_accept) begin
          // Write-addressed slot update; compare avoids an out-of-range index.
          for (int i = 0; i < int'(NDATA); i++) begin
            if (r_idx == CW'(i)) w_slot_n[i] = i_data;
          end
          if (i_last) begin
            w_state_n = HOLD;
            w_count_n = r_idx + CW'(1);
            w_short_n = (r_idx != CW'(NDATA - 1));
            w_trunc_n = 1'b0;
          end else if (r_idx == CW'(NDATA - 1)) begin
            w_state_n = HOLD;
            w_count_n = CW'(NDATA);
            w_short_n = 1'b0;
            w_trunc_n = 1'b1;
          end else begin
            w_idx_n = r_idx + CW'(1);
          end
        end
      end
      HOLD: begin
        if (i_ready) begin
          for (int i = 0; i < int'(NDATA); i++) w_slot_n[i] = PAD;
          w_idx_n   = '0;
          w_count_n = '0;
          w_short_n = 1'b0;
          // o_trunc stays set through DROP so downstream sees the discard.
          w_state_n = r_trunc ? DROP : COLLECT;
        end
      end
      DROP: begin
        if (w_accept && i_last) begin
          w_trunc_n = 1'b0;
          w_state_n = COLLECT;
        end
      end
      default: w_state_n = COLLECT;
    endcase

    // Handshake outputs follow the state being entered, so they are registered.
    w_valid_n = (w_state_n == HOLD);
    w_ready_n = (w_state_n != HOLD);
  end

  assign o_ready = r_ready;
  assign o_valid = r_valid;
  assign o_data  = r_slot;
  assign o_count = r_count;
  assign o_short = r_short;
  assign o_trunc = r_trunc;

endmodule

// File: tb/tb_frame_deserializer.sv
// Scoreboard bench for frame_deserializer (BIT=8, NDATA=3, PAD=0xEE).
module tb_frame_deserializer;

  localparam int unsigned BIT   = 8;
  localparam int unsigned NDATA = 3;
  localparam int unsigned CW    = 2;
  localparam logic [7:0]  PAD   = 8'hEE;

  logic           i_clk = 1'b0;
  logic           i_rst;
  logic           i_valid;
  logic           o_ready;
  logic [BIT-1:0] i_data;
  logic           i_last;
  logic           o_valid;
  logic           i_ready;
  logic [BIT-1:0] o_data [0:NDATA-1];
  logic [CW-1:0]  o_count;
  logic           o_short;
  logic           o_trunc;

  frame_deserializer #(.BIT(BIT), .NDATA(NDATA), .PAD(PAD)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data), .i_last(i_last),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
    .o_count(o_count), .o_short(o_short), .o_trunc(o_trunc)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [2:0][7:0] d;
    logic [1:0]      cnt;
    logic            sh;
    logic            tr;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_pad(input string tag);
    for (int i = 0; i < int'(NDATA); i++)
      chk($sformatf("%s slot%0d", tag, i), 32'(o_data[i]), 32'(PAD));
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                      input logic [1:0] cnt, input logic sh, input logic tr);
    exp_t e;
    e.d[0] = a; e.d[1] = b; e.d[2] = c;
    e.cnt = cnt; e.sh = sh; e.tr = tr;
    q.push_back(e);
  endtask

  // Present a word from a falling edge until it is accepted on a rising edge.
  task automatic send(input logic [7:0] d, input logic l);
    int n = 0;
    @(negedge i_clk);
    i_valid = 1'b1; i_data = d; i_last = l;
    while (!o_ready && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_ready) begin
      n_tests++; n_fail++;
      $display("FAIL send timeout: word 0x%0h never accepted", d);
    end
    @(posedge i_clk);
    #1;
    i_valid = 1'b0; i_last = 1'b0;
  endtask

  // Monitor: compare every frame handed off against the scoreboard.
  always @(negedge i_clk) begin
    if (!i_rst && o_valid && i_ready) begin
      if (q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected frame: got slot0=0x%0h count=%0d, none expected", o_data[0], o_count);
      end else begin
        m_e = q.pop_front();
        for (int i = 0; i < int'(NDATA); i++)
          chk($sformatf("frame slot%0d", i), 32'(o_data[i]), 32'(m_e.d[i]));
        chk("frame count", 32'(o_count), 32'(m_e.cnt));
        chk("frame short", 32'(o_short), 32'(m_e.sh));
        chk("frame trunc", 32'(o_trunc), 32'(m_e.tr));
        chk("short/trunc exclusive", 32'(o_short & o_trunc), 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    i_rst = 1'b1; i_valid = 1'b0; i_data = '0; i_last = 1'b0; i_ready = 1'b1;

    // Reset state
    #12;
    chk("rst valid", 32'(o_valid), 32'd0);
    chk("rst ready", 32'(o_ready), 32'd0);
    chk("rst count", 32'(o_count), 32'd0);
    chk("rst short", 32'(o_short), 32'd0);
    chk("rst trunc", 32'(o_trunc), 32'd0);
    chk_pad("rst");
    #1 i_rst = 1'b0;
    #1 chk("ready low before edge", 32'(o_ready), 32'd0);
    @(negedge i_clk);
    chk("ready after release", 32'(o_ready), 32'd1);

    // Full frame, one bubble
    push(8'h11, 8'h22, 8'h33, 2'd3, 1'b0, 1'b0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b1);
    @(negedge i_clk);
    chk("full valid latency", 32'(o_valid), 32'd1);
    chk("full ready bubble", 32'(o_ready), 32'd0);
    @(negedge i_clk);
    chk("full ready back", 32'(o_ready), 32'd1);
    chk("full valid dropped", 32'(o_valid), 32'd0);

    // Short frame padded
    push(8'hA1, PAD, PAD, 2'd1, 1'b1, 1'b0);
    send(8'hA1, 1'b1);
    @(negedge i_clk);

    // Truncation, drop, then intact frame
    push(8'h01, 8'h02, 8'h03, 2'd3, 1'b0, 1'b1);
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);
    @(negedge i_clk);
    chk("drop trunc held", 32'(o_trunc), 32'd1);
    chk("drop no valid", 32'(o_valid), 32'd0);
    chk("drop ready", 32'(o_ready), 32'd1);
    send(8'h05, 1'b1);
    @(negedge i_clk);
    chk("drop trunc cleared", 32'(o_trunc), 32'd0);
    chk("drop nothing emitted", 32'(o_valid), 32'd0);
    push(8'h07, 8'h08, 8'h09, 2'd3, 1'b0, 1'b0);
    send(8'h07, 1'b0);
    send(8'h08, 1'b0);
    send(8'h09, 1'b1);
    @(negedge i_clk);

    // Backpressure for 10 cycles
    @(posedge i_clk);
    #1 i_ready = 1'b0;
    push(8'h41, 8'h42, 8'h43, 2'd3, 1'b0, 1'b0);
    send(8'h41, 1'b0);
    send(8'h42, 1'b0);
    send(8'h43, 1'b1);
    i_valid = 1'b1; i_data = 8'h99; i_last = 1'b1;
    repeat (10) begin
      @(negedge i_clk);
      chk("bp valid", 32'(o_valid), 32'd1);
      chk("bp ready", 32'(o_ready), 32'd0);
      chk("bp slot0", 32'(o_data[0]), 32'h41);
      chk("bp slot2", 32'(o_data[2]), 32'h43);
    end
    i_valid = 1'b0; i_last = 1'b0;
    @(posedge i_clk);
    #1 i_ready = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    chk("bp released valid", 32'(o_valid), 32'd0);
    chk("bp released ready", 32'(o_ready), 32'd1);

    // Bubbly input
    push(8'h10, 8'h20, 8'h30, 2'd3, 1'b0, 1'b0);
    send(8'h10, 1'b0);
    repeat (2) @(posedge i_clk);
    send(8'h20, 1'b0);
    @(posedge i_clk);
    send(8'h30, 1'b1);
    @(negedge i_clk);

    // Reset mid-frame
    send(8'h51, 1'b0);
    send(8'h52, 1'b0);
    #3 i_rst = 1'b1;
    #1;
    chk("midrst valid", 32'(o_valid), 32'd0);
    chk("midrst ready", 32'(o_ready), 32'd0);
    chk("midrst count", 32'(o_count), 32'd0);
    chk_pad("midrst");
    #3 i_rst = 1'b0;
    push(8'h61, 8'h62, 8'h63, 2'd3, 1'b0, 1'b0);
    send(8'h61, 1'b0);
    send(8'h62, 1'b0);
    send(8'h63, 1'b1);

    // Drain scoreboard
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    chk("scoreboard drained", 32'(q.size()), 32'd0);
    @(negedge i_clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
